// File: rtl/risc_pkg.sv
// Shared types for the RISC core front end.
// Widths and the fetch FSM state encoding.
package risc_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    HOLD = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus: instruction memory read port and the
// decoder valid/ready handshake; master = fetch side.
interface fetch_unit_if;
  import risc_pkg::*;

  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;

  modport master (
    output mem_rd,
    output mem_addr,
    output instr,
    output instr_pc,
    output instr_valid,
    input  mem_ack,
    input  mem_rdata,
    input  instr_ready
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output mem_ack,
    output mem_rdata,
    output instr_ready
  );

endinterface

// File: rtl/fetch_ir_reg.sv
// Width-parameterised register, sync active-high reset.
// Ports: clk, reset, i_ld (load enable), i_d, o_q.
module fetch_ir_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_ld,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: IDLE -> REQ -> HOLD.
// Ports: clk, reset, pc, flush, loadpc, busy, bus (master).
module fetch_unit
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              loadpc,
  output logic              busy,
  fetch_unit_if.master      bus
);

  fetch_state_t r_state;
  fetch_state_t w_next;

  logic r_mem_rd;
  logic r_valid;
  logic r_loadpc;

  logic w_take;
  logic w_addr_ld;
  logic w_rd_d;
  logic w_valid_d;

  logic [ADDR_W-1:0]  w_addr;
  logic [INSTR_W-1:0] w_instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE: w_next = REQ;
        REQ:  if (bus.mem_ack) w_next = HOLD;
        HOLD: if (r_valid && bus.instr_ready)
                w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Registered outputs are computed from the next
  // state, so they line up with the state they belong to.
  always_comb begin
    w_take    = (r_state == REQ) && bus.mem_ack && !flush;
    w_addr_ld = (r_state == IDLE);
    w_rd_d    = (w_next == REQ);
    w_valid_d = (w_next == HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_rd <= 1'b0;
      r_valid  <= 1'b0;
      r_loadpc <= 1'b0;
    end else begin
      r_mem_rd <= w_rd_d;
      r_valid  <= w_valid_d;
      r_loadpc <= w_take;
    end
  end

  // One address register: it is only reloaded in IDLE,
  // so it still names the held word while in HOLD.
  fetch_ir_reg #(.W(ADDR_W)) u_addr (
    .clk   (clk),
    .reset (reset),
    .i_ld  (w_addr_ld),
    .i_d   (pc),
    .o_q   (w_addr)
  );

  fetch_ir_reg #(.W(INSTR_W)) u_instr (
    .clk   (clk),
    .reset (reset),
    .i_ld  (w_take),
    .i_d   (bus.mem_rdata),
    .o_q   (w_instr)
  );

  assign bus.mem_rd      = r_mem_rd;
  assign bus.mem_addr    = w_addr;
  assign bus.instr       = w_instr;
  assign bus.instr_pc    = w_addr;
  assign bus.instr_valid = r_valid;

  // A redirect overrides a pending increment so the
  // counter never steps past the new target.
  assign loadpc = r_loadpc && !flush;
  assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: acts as counter, memory and
// decoder; vector table plus flush/reset sequences.
module tb_fetch_unit;

  typedef struct {
    logic        set_pc;
    logic [7:0]  pc;
    logic [15:0] rdata;
    int          waits;
    int          stall;
    logic [7:0]  exp_addr;
  } vec_t;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  pc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] pc;
  logic       flush;
  logic       loadpc;
  logic       busy;

  int n_pass;
  int n_total;

  vec_t vecs[5];
  exp_t sb[$];

  fetch_unit_if bus();

  fetch_unit dut (
    .clk    (clk),
    .reset  (reset),
    .pc     (pc),
    .flush  (flush),
    .loadpc (loadpc),
    .busy   (busy),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h",
                  nm, act, exp);
  endtask

  task automatic run_row(input vec_t v);
    exp_t e;
    chk("idle_busy", busy, 0);
    if (v.set_pc) pc = v.pc;
    tick;
    chk("req_rd", bus.mem_rd, 1);
    chk("req_addr", bus.mem_addr, v.exp_addr);
    chk("req_busy", busy, 1);
    for (int w = 0; w < v.waits; w++) begin
      bus.mem_ack = 1'b0;
      tick;
      chk("wait_rd", bus.mem_rd, 1);
      chk("wait_addr", bus.mem_addr, v.exp_addr);
      chk("wait_valid", bus.instr_valid, 0);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = v.rdata;
    e.instr = v.rdata;
    e.pc    = v.exp_addr;
    sb.push_back(e);
    bus.instr_ready = (v.stall == 0);
    tick;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0;
    chk("hold_valid", bus.instr_valid, 1);
    chk("hold_loadpc", loadpc, 1);
    chk("hold_rd", bus.mem_rd, 0);
    if (loadpc) pc = pc + 8'd1;
    for (int s = 0; s < v.stall; s++) begin
      tick;
      chk("stall_valid", bus.instr_valid, 1);
      chk("stall_loadpc", loadpc, 0);
      chk("stall_rd", bus.mem_rd, 0);
      chk("stall_instr", bus.instr, v.rdata);
      chk("stall_pc", bus.instr_pc, v.exp_addr);
    end
    bus.instr_ready = 1'b1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("xfer_instr", bus.instr, e.instr);
      chk("xfer_pc", bus.instr_pc, e.pc);
    end
    tick;
    bus.instr_ready = 1'b0;
    chk("post_valid", bus.instr_valid, 0);
    chk("post_loadpc", loadpc, 0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    vecs[0] = '{1'b1, 8'h10, 16'hA5C3, 0, 0, 8'h10};
    vecs[1] = '{1'b0, 8'h00, 16'h1111, 4, 0, 8'h11};
    vecs[2] = '{1'b0, 8'h00, 16'hBEEF, 1, 6, 8'h12};
    vecs[3] = '{1'b1, 8'hFF, 16'h7E01, 0, 0, 8'hFF};
    vecs[4] = '{1'b0, 8'h00, 16'h0042, 2, 1, 8'h00};

    reset = 1'b1;
    pc    = 8'h00;
    flush = 1'b0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = 16'h0;
    bus.instr_ready = 1'b0;
    tick;
    tick;
    chk("rst_rd", bus.mem_rd, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_ipc", bus.instr_pc, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_loadpc", loadpc, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_row(vecs[i]);

    // flush coincident with ack in REQ
    pc = 8'h20;
    tick;
    chk("fa_addr", bus.mem_addr, 8'h20);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h1234;
    flush = 1'b1;
    pc    = 8'h40;
    tick;
    flush = 1'b0;
    bus.mem_ack = 1'b0;
    chk("fa_valid", bus.instr_valid, 0);
    chk("fa_loadpc", loadpc, 0);
    chk("fa_rd", bus.mem_rd, 0);
    chk("fa_busy", busy, 0);
    run_row('{1'b0, 8'h00, 16'h5555, 0, 0, 8'h40});

    // flush in HOLD while decoder is ready
    tick;
    chk("fb_addr", bus.mem_addr, 8'h41);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    tick;
    bus.mem_ack = 1'b0;
    chk("fb_valid", bus.instr_valid, 1);
    chk("fb_loadpc", loadpc, 1);
    if (loadpc) pc = pc + 8'd1;
    tick;
    chk("fb_hold", bus.instr_valid, 1);
    flush = 1'b1;
    bus.instr_ready = 1'b1;
    pc = 8'h80;
    tick;
    flush = 1'b0;
    bus.instr_ready = 1'b0;
    chk("fb_novalid", bus.instr_valid, 0);
    chk("fb_busy", busy, 0);
    chk("fb_noload", loadpc, 0);
    chk("fb_noxfer", sb.size(), 0);
    run_row('{1'b0, 8'h00, 16'hC0DE, 1, 0, 8'h80});

    // reset in the middle of a waiting REQ
    tick;
    tick;
    chk("rr_rd", bus.mem_rd, 1);
    reset = 1'b1;
    tick;
    chk("rr_rd0", bus.mem_rd, 0);
    chk("rr_addr", bus.mem_addr, 0);
    chk("rr_instr", bus.instr, 0);
    chk("rr_ipc", bus.instr_pc, 0);
    chk("rr_valid", bus.instr_valid, 0);
    chk("rr_loadpc", loadpc, 0);
    chk("rr_busy", busy, 0);
    reset = 1'b0;
    pc = 8'h00;
    run_row('{1'b0, 8'h00, 16'h600D, 0, 0, 8'h00});

    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 8-bit-address RISC core. It consumes the address produced by the program counter and issues a read request to instruction memory. It latches the returned 16-bit instruction and hands it to the decoder over a valid/ready handshake. It pulses `loadpc` back to the counter once per fetched instruction and abandons in-flight work when the core redirects the PC.

## Interface
- `ADDR_W`, 8, width of the instruction address and of `pc`.
- `INSTR_W`, 16, instruction word width.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; one clock; sampled on rising `clk`.
- `pc`  in  ADDR_W  current program counter value from the counter.
- `flush`  in  1  PC redirect (jump/branch taken); discards the current fetch.
- `mem_rd`  out  1  instruction memory read request.
- `mem_addr`  out  ADDR_W  read address, stable while `mem_rd`=1.
- `mem_ack`  in  1  memory read completion; meaningful only while `mem_rd`=1.
- `mem_rdata`  in  INSTR_W  instruction word, valid in the `mem_ack` cycle.
- `instr`  out  INSTR_W  fetched instruction to the decoder.
- `instr_pc`  out  ADDR_W  address the instruction was fetched from.
- `instr_valid`  out  1  `instr`/`instr_pc` hold a valid word.
- `instr_ready`  in  1  decoder accepts the word this cycle.
- `loadpc`  out  1  one-cycle pulse; tells the counter to increment.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- **States:** IDLE, REQ, HOLD. All outputs are registered.
- **IDLE:** capture `pc` into the address register. Next state is REQ.
- **REQ:**
  - `mem_rd`=1 and `mem_addr`=captured address, held constant until ack.
  - On `mem_ack`: latch `mem_rdata` into `instr` and the address into `instr_pc`, set `instr_valid`, pulse `loadpc` in the next cycle, go to HOLD.
  - Memory wait states of any length are allowed; the unit has no timeout.
- **HOLD:**
  - `instr_valid`=1; `instr` and `instr_pc` stay stable.
  - When `instr_valid`&`instr_ready`: clear `instr_valid`, go to IDLE.
- **flush (any state, highest priority):**
  - Next state is IDLE; `instr_valid` clears.
  - No `loadpc` pulse is issued. An ack in the same cycle is ignored, and an accept in the same cycle does not count as a transfer.
  - If the unit is in REQ, `mem_rd` drops next cycle. Memory treats a `mem_rd` deassertion before ack as an abort.
- `loadpc` pulses exactly once per instruction that reaches HOLD and never while `flush`=1.
- **Address width:** `pc` is not modified; the counter alone performs the 8-bit wrap from 0xFF to 0x00.

## Timing
- **Reset values:** state=IDLE; `mem_rd`, `mem_addr`, `instr`, `instr_pc`, `instr_valid`, `loadpc` all 0. `busy` is 0.
- **Zero-wait memory** (ack in the first REQ cycle):
  - c0: IDLE
  - c1: REQ with ack
  - c2: HOLD, `instr_valid`=1, `loadpc`=1
  - Best-case throughput is one instruction per 3 cycles.
- The counter updates at the end of the `loadpc` cycle. The next IDLE is therefore at or after c3, so it always captures the incremented `pc`.
- Each memory wait cycle adds 1 cycle. Each cycle of decoder backpressure adds 1 cycle in HOLD.
- **Reset mid-REQ:** `mem_rd`=0 on the next cycle, and no `loadpc` is issued.

## Structure
- Shared package `risc_pkg`:
  - `ADDR_W`=8 and `INSTR_W`=16.
  - `fetch_state_t` enum: IDLE=2'b00, REQ=2'b01, HOLD=2'b10.
- One natural sub-module, `fetch_ir_reg`: a width-parameterised register with sync reset and load enable. It is instantiated for `instr` and for `instr_pc`/`mem_addr`. The FSM is inline in `fetch_unit`.

## Test plan
- **Basic fetch:** `pc`=0x10, ack in first REQ cycle, `instr_ready`=1, `mem_rdata`=0xA5C3.
  - Required: `instr`=0xA5C3, `instr_pc`=0x10, valid in cycle 2.
  - Exactly one `loadpc` pulse.
  - The next `mem_addr` equals the counter value 0x11.
- **Wait states:** ack delayed 4 cycles.
  - Required: `mem_rd` high with `mem_addr` stable for all 5 REQ cycles, and `instr_valid` 1 cycle after ack.
- **Backpressure:** `instr_ready`=0 for 6 cycles in HOLD.
  - Required: `instr`/`instr_pc` stable and `instr_valid`=1 throughout.
  - No second `loadpc` and no new `mem_rd` until accept.
- **Flush:**
  - Flush in REQ coincident with ack (0x1234): instruction discarded, no `loadpc`, next IDLE captures the redirected `pc`=0x40.
  - Flush in HOLD with `instr_ready`=1: no transfer.
- **Reset:** assert `reset` mid-REQ.
  - Required: all outputs 0 next cycle and state IDLE.
  - Fetch restarts from `pc`=0x00 after release.
- **Wrap:** `pc`=0xFF.
  - Required: `instr_pc`=0xFF, then the next request is at `mem_addr`=0x00.
